pe_dot_accum_ctrl: RTL and testbench

Sequencing controller for the PE dot-product adder tree. Accepts a job command giving a number of DOT_SIZE-wide vector chunks and gates chunk issue from upstream into the multiplier/adder-tree pipeline. It tracks in-flight chunks through the fixed-latency, non-stallable tree and accumulates the returning tree sums into a wide signed accumulator. It presents the final dot product on a valid/ready output. Sits between the PE feeder (operand buffers) and the PE result/drain logic.

---
 rtl/pe_dot_accum_ctrl.sv | 149 ++++++++++++++
 tb/tb_pe_dot_accum_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_accum_ctrl.sv
// PE dot-product sequencing controller: gates chunk issue into the adder
// tree, tracks in-flight chunks and accumulates returning tree sums.
module pe_dot_accum_ctrl #(
  parameter int DOT_OUTPUT_WIDTH = 20,
  parameter int ACC_WIDTH        = 32,
  parameter int TREE_LATENCY     = 4,
  parameter int CHUNK_WIDTH      = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [CHUNK_WIDTH-1:0]             cmd_chunks,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               issue,
  input  logic signed [DOT_OUTPUT_WIDTH-1:0] tree_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [ACC_WIDTH-1:0]        out_result,
  output logic                               out_overflow,
  output logic                               busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CHUNK_WIDTH-1:0] ONE = CHUNK_WIDTH'(1);

  state_t state;
  state_t state_n;

  logic [CHUNK_WIDTH-1:0]  chunks;
  logic [CHUNK_WIDTH-1:0]  issue_cnt;
  logic [CHUNK_WIDTH-1:0]  ret_cnt;
  logic [TREE_LATENCY-1:0] vpipe;

  logic                        ret;
  logic                        ret_live;
  logic                        last_ret;
  logic                        last_issue;
  logic                        accept;
  logic                        ovf_step;
  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] sum;

  assign ret        = vpipe[TREE_LATENCY-1];
  assign ret_live   = ret && ((state == RUN) || (state == DRAIN));
  assign last_ret   = ret_live && ((ret_cnt + ONE) == chunks);
  assign last_issue = in_valid && ((issue_cnt + ONE) == chunks);
  assign accept     = cmd_valid && cmd_ready;
  assign issue      = in_valid && in_ready;
  assign busy       = (state != IDLE);

  assign ext      = ACC_WIDTH'(tree_result);
  assign sum      = out_result + ext;
  assign ovf_step = (out_result[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != out_result[ACC_WIDTH-1]);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and state-decoded handshake outputs
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_n = (cmd_chunks == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (last_ret) begin
          state_n = DONE;
        end else if (last_issue) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (last_ret) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Issue tracking pipe: tail marks a valid tree return this cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < TREE_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  // Job counters, accumulator and sticky overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chunks       <= '0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
    end else if (accept) begin
      chunks       <= cmd_chunks;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (issue) begin
        issue_cnt <= issue_cnt + ONE;
      end
      if (ret_live) begin
        out_result <= sum;
        ret_cnt    <= ret_cnt + ONE;
        if (ovf_step) begin
          out_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_dot_accum_ctrl.sv
// Scoreboard bench for pe_dot_accum_ctrl: a 32-bit and a 20-bit
// accumulator instance share stimulus and a modelled adder tree.
module tb_pe_dot_accum_ctrl;

  localparam int DW  = 20;
  localparam int AW  = 32;
  localparam int AW2 = 20;
  localparam int TL  = 4;
  localparam int CW  = 8;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [CW-1:0]         cmd_chunks = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  issue;
  logic signed [DW-1:0]  tree_result = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic signed [AW-1:0]  out_result;
  logic                  out_overflow;
  logic                  busy;

  logic                  b_cmd_ready;
  logic                  b_in_ready;
  logic                  b_issue;
  logic                  b_out_valid;
  logic signed [AW2-1:0] b_out_result;
  logic                  b_out_overflow;
  logic                  b_busy;

  pe_dot_accum_ctrl #(
    .DOT_OUTPUT_WIDTH(DW), .ACC_WIDTH(AW),
    .TREE_LATENCY(TL), .CHUNK_WIDTH(CW)
  ) u_dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chunks(cmd_chunks),
    .in_valid(in_valid), .in_ready(in_ready), .issue(issue),
    .tree_result(tree_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .busy(busy)
  );

  pe_dot_accum_ctrl #(
    .DOT_OUTPUT_WIDTH(DW), .ACC_WIDTH(AW2),
    .TREE_LATENCY(TL), .CHUNK_WIDTH(CW)
  ) u_w20 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_chunks(cmd_chunks),
    .in_valid(in_valid), .in_ready(b_in_ready), .issue(b_issue),
    .tree_result(tree_result),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_out_result), .out_overflow(b_out_overflow),
    .busy(b_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int     n;
    longint r32;
    bit     o32;
    longint r20;
    bit     o20;
  } exp_t;

  exp_t   exp_q[$];
  int     tree_q[$];
  int     errors = 0;
  int     checks = 0;
  int     issued = 0;
  int     cyc = 0;
  int     last_issue_cyc = 0;
  logic signed [DW-1:0] tp_v [TL];
  bit     tp_ok [TL];

  task automatic check(input string name, input longint act,
                       input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Reference: running signed sum in a w-bit register, flag any step
  // whose true sum leaves the representable range.
  task automatic model(input int vals[$], input int w,
                       output longint r, output bit o);
    longint a;
    longint t;
    longint hi;
    longint lo;
    a  = 0;
    o  = 0;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    foreach (vals[i]) begin
      t = a + vals[i];
      if (t > hi || t < lo) o = 1;
      a = wrapw(t, w);
    end
    r = a;
  endtask

  // Adder-tree model: returns the issued chunk's value TL cycles later,
  // garbage otherwise; also flags any issue with no chunk pending.
  always @(posedge clock) begin
    for (int i = TL - 1; i > 0; i--) begin
      tp_v[i]  = tp_v[i-1];
      tp_ok[i] = tp_ok[i-1];
    end
    tp_v[0]  = '0;
    tp_ok[0] = 1'b0;
    if (issue === 1'b1) begin
      last_issue_cyc = cyc;
      issued++;
      check("issue_in_run", longint'(tree_q.size() > 0), 1);
      if (tree_q.size() > 0) begin
        tp_v[0]  = DW'(tree_q.pop_front());
        tp_ok[0] = 1'b1;
      end
    end
    cyc++;
    #1;
    tree_result = tp_ok[TL-1] ? tp_v[TL-1] : DW'($urandom);
  end

  // Monitor: compares presented results with the scoreboard head.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q[0];
        check("result32", out_result, e.r32);
        check("ovf32", out_overflow, longint'(e.o32));
        check("result20", b_out_result, e.r20);
        check("ovf20", b_out_overflow, longint'(e.o20));
        if (out_ready === 1'b1) begin
          check("issue_count", issued, e.n);
          check("w20_valid", b_out_valid, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // mode 0: back-to-back, 1: toggling in_valid, 2: random gaps
  task automatic do_job(input int vals[$], input int mode,
                        input int hold);
    exp_t e;
    int   n;
    int   t;
    n   = vals.size();
    e.n = n;
    model(vals, AW, e.r32, e.o32);
    model(vals, AW2, e.r20, e.o20);
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clock); #1; t++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    issued = 0;
    exp_q.push_back(e);
    foreach (vals[i]) tree_q.push_back(vals[i]);
    out_ready  = (hold == 0);
    cmd_valid  = 1'b1;
    cmd_chunks = CW'(n);
    @(posedge clock); #1;
    cmd_valid  = 1'b0;
    cmd_chunks = CW'($urandom);
    if (n == 0) begin
      check("zero_busy", busy, 1);
      check("zero_valid", out_valid, 1);
    end
    t = 0;
    while (issued < n && t < 5000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (t % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clock); #1; t++;
    end
    check("all_issued", issued, n);
    if (mode == 1) check("toggle_cycles", t, 2 * n - 1);
    in_valid = ($urandom_range(0, 1) == 1);
    t = 0;
    while (out_valid !== 1'b1 && t < 100) begin
      in_valid = ($urandom_range(0, 1) == 1);
      @(posedge clock); #1; t++;
    end
    check("out_valid_seen", out_valid, 1);
    if (n > 0) check("latency", cyc - last_issue_cyc, TL + 1);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clock); #1;
        check("held_valid", out_valid, 1);
      end
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
    check("idle_after_accept", cmd_ready, 1);
    check("valid_dropped", out_valid, 0);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_issue"}, issue, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_out_overflow"}, out_overflow, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v[$];
    int t;
    int n;
    int r;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    v = {10, -3, 7, 100};
    do_job(v, 0, 0);

    v = {};
    do_job(v, 0, 0);

    v = {-20, 33, 1000};
    do_job(v, 1, 6);

    v = {262144, 262144};
    do_job(v, 0, 0);
    v = {5};
    do_job(v, 0, 0);

    // Reset two cycles after the second of five issues
    issued = 0;
    for (int i = 0; i < 5; i++) tree_q.push_back(1000 + i);
    cmd_valid  = 1'b1;
    cmd_chunks = CW'(5);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    t = 0;
    while (issued < 2 && t < 50) begin
      @(posedge clock); #1; t++;
    end
    check("pre_reset_issues", issued, 2);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("midjob");
    tree_q.delete();
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("reset_no_valid", out_valid, 0);
    reset = 1'b0;
    v = {-7};
    do_job(v, 0, 0);

    repeat (20) begin
      v = {};
      n = $urandom_range(1, 255);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, (1 << DW) - 1) - (1 << (DW - 1));
        v.push_back(r);
      end
      do_job(v, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (8) @(posedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
